switch_input_port: RTL

Memory-mapped input peripheral: the input-direction counterpart of the memory block's seven-segment display output. It synchronises and debounces raw switch/button lines and latches rising edges in a sticky register. It answers control-unit read/write transactions on the shared 32-bit tri-state `bus` and raises a level interrupt for enabled edges.

---
 rtl/switch_io_pkg.sv | 25 ++
 rtl/debounce_bit.sv | 53 +++++
 rtl/switch_input_port.sv | 124 ++++++++++++
 3 files changed

// File: rtl/switch_io_pkg.sv
`default_nettype none
// ============================================================================
// Package : switch_io_pkg
// Brief   : Shared types and constants for the switch input peripheral.
// Rev     : 1.0 - initial release
// ============================================================================
package switch_io_pkg;

    typedef enum logic [1:0] {
        REG_STATE  = 2'd0,
        REG_EDGES  = 2'd1,
        REG_IRQ_EN = 2'd2,
        REG_ID     = 2'd3
    } io_reg_e;

    typedef enum logic [1:0] {
        IO_IDLE    = 2'd0,
        IO_RESPOND = 2'd1,
        IO_HOLD    = 2'd2
    } io_state_e;

    localparam logic [31:0] SWITCH_IO_ID = 32'h5357_0001;

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module : debounce_bit
// Brief  : Two-flop synchroniser plus stable-count debouncer for one line.
// Rev    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_deb,
    output logic o_rise
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_deb;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;

    // New level is accepted on the edge the counter sits at its final value.
    assign w_accept = (r_sync2 != r_deb) && (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = w_accept && r_sync2;

endmodule
`default_nettype wire

// File: rtl/switch_input_port.sv
`default_nettype none
// ============================================================================
// Module : switch_input_port
// Brief  : Debounced switch inputs with sticky edges, IRQ mask and bus access.
// Rev    : 1.0 - initial release
// ============================================================================
module switch_input_port
    import switch_io_pkg::*;
#(
    parameter int NUM_INPUTS      = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    inout  wire  [31:0]           bus,
    input  logic                  io_select,
    input  logic                  io_read,
    input  logic                  io_write,
    input  logic [1:0]            io_address,
    output logic                  io_ack,
    input  logic [NUM_INPUTS-1:0] switches,
    output logic                  irq
);

    localparam logic [1:0] c_idle    = IO_IDLE;
    localparam logic [1:0] c_respond = IO_RESPOND;
    localparam logic [1:0] c_hold    = IO_HOLD;

    logic [NUM_INPUTS-1:0] w_deb;
    logic [NUM_INPUTS-1:0] w_rise;
    logic [NUM_INPUTS-1:0] w_clr;
    logic [NUM_INPUTS-1:0] r_edges;
    logic [NUM_INPUTS-1:0] r_irq_en;
    logic [1:0]            r_state;
    logic                  r_drive;
    logic [31:0]           r_rdata;
    logic [31:0]           w_rd_mux;
    logic                  w_req;
    logic                  w_start;
    logic                  w_wr;
    logic                  w_unused_bus;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clock),
                .rst    (reset),
                .i_raw  (switches[gi]),
                .o_deb  (w_deb[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_req   = io_select && (io_read || io_write);
    assign w_start = (r_state == c_idle) && w_req;
    // A simultaneous read and write is serviced as a read only.
    assign w_wr    = w_start && io_write && !io_read;
    assign w_clr   = (w_wr && io_address == REG_EDGES) ? bus[NUM_INPUTS-1:0] : '0;
    assign w_unused_bus = ^bus;

    always_comb begin
        w_rd_mux = '0;
        case (io_address)
            REG_STATE:  w_rd_mux[NUM_INPUTS-1:0] = w_deb;
            REG_EDGES:  w_rd_mux[NUM_INPUTS-1:0] = r_edges;
            REG_IRQ_EN: w_rd_mux[NUM_INPUTS-1:0] = r_irq_en;
            REG_ID:     w_rd_mux = SWITCH_IO_ID;
            default:    w_rd_mux = '0;
        endcase
    end

    // A rise landing on the same edge as its clear keeps the bit set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_edges  <= '0;
            r_irq_en <= '0;
        end else begin
            r_edges <= (r_edges & ~w_clr) | w_rise;
            if (w_wr && io_address == REG_IRQ_EN) begin
                r_irq_en <= bus[NUM_INPUTS-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_idle;
            r_drive <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_req) begin
                        r_state <= c_respond;
                        r_drive <= io_read;
                        r_rdata <= w_rd_mux;
                    end
                end
                c_respond: begin
                    r_state <= c_hold;
                end
                c_hold: begin
                    if (!w_req) begin
                        r_state <= c_idle;
                        r_drive <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_drive <= 1'b0;
                end
            endcase
        end
    end

    assign io_ack = (r_state == c_respond);
    assign bus    = r_drive ? r_rdata : 'z;
    assign irq    = |(r_edges & r_irq_en);

endmodule
`default_nettype wire
